// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin tri-state bus arbiter.
package bus_arb_pkg;

   localparam int DEF_N_REQ    = 4;
   localparam int DEF_MAX_HOLD = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } arb_state_t;

   // Bits needed to hold values 0..value-1, never less than one bit.
   function automatic int clog2_width(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after last_id, wrapping modulo N_REQ.
module rr_picker
   import bus_arb_pkg::*;
#(
   parameter  int N_REQ = DEF_N_REQ,
   localparam int ID_W  = clog2_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  last_id,
   output logic             found,
   output logic [ID_W-1:0]  win_id
);

   logic [ID_W-1:0] idx;

   always_comb begin
      found  = 1'b0;
      win_id = '0;
      idx    = '0;
      // Offset 1 first, last_id itself last, so the previous owner has lowest priority.
      for (int i = 1; i <= N_REQ; i++) begin
         idx = ID_W'((int'(last_id) + i) % N_REQ);
         if (!found && req[idx]) begin
            found  = 1'b1;
            win_id = idx;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter producing one-hot driver enables with a forced idle cycle between owners
// and a hold-time limit that force-releases a long-running owner.
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter  int N_REQ    = DEF_N_REQ,
   parameter  int MAX_HOLD = DEF_MAX_HOLD,
   localparam int ID_W     = clog2_width(N_REQ),
   localparam int CNT_W    = clog2_width(MAX_HOLD + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] drive_en,
   output logic [ID_W-1:0]  grant_id,
   output logic             bus_busy,
   output logic             timeout,
   output arb_state_t       fsm_state
);

   arb_state_t       state_q, state_d;
   logic [ID_W-1:0]  last_id_q, last_id_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [N_REQ-1:0] drive_d;
   logic [ID_W-1:0]  grant_d;
   logic             timeout_d;
   logic             found;
   logic [ID_W-1:0]  win_id;

   rr_picker #(.N_REQ(N_REQ)) u_picker (
      .req     (req),
      .last_id (last_id_q),
      .found   (found),
      .win_id  (win_id)
   );

   always_comb begin
      state_d   = state_q;
      last_id_d = last_id_q;
      hold_d    = hold_q;
      drive_d   = '0;
      grant_d   = grant_id;
      timeout_d = 1'b0;
      case (state_q)
         IDLE, TURN: begin
            // TURN keeps drive_en low for this cycle even when a new winner is chosen.
            if (found) begin
               state_d   = GRANT;
               drive_d   = N_REQ'(1) << win_id;
               grant_d   = win_id;
               hold_d    = CNT_W'(1);
               last_id_d = win_id;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            if (!req[grant_id]) begin
               state_d = TURN;
            end else if (hold_q == CNT_W'(MAX_HOLD)) begin
               state_d   = TURN;
               timeout_d = 1'b1;
            end else begin
               hold_d  = hold_q + CNT_W'(1);
               drive_d = drive_en;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         last_id_q <= ID_W'(N_REQ - 1);
         hold_q    <= '0;
         drive_en  <= '0;
         grant_id  <= '0;
         bus_busy  <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_id_q <= last_id_d;
         hold_q    <= hold_d;
         drive_en  <= drive_d;
         grant_id  <= grant_d;
         bus_busy  <= |drive_d;
         timeout   <= timeout_d;
      end
   end

   assign fsm_state = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed scenarios plus randomized requests vs. an ownership model.
module tb_bus_arbiter;
   import bus_arb_pkg::*;

   localparam int N            = 4;
   localparam int MAXH         = 4;
   localparam int IDW          = 2;
   localparam int W            = N + IDW + 2;
   localparam int STARVE_LIMIT = N * (MAXH + 1);

   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req   = '0;
   logic [N-1:0]   drive_en;
   logic [IDW-1:0] grant_id;
   logic           bus_busy;
   logic           timeout;
   arb_state_t     fsm_state;

   bus_arbiter #(.N_REQ(N), .MAX_HOLD(MAXH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .drive_en  (drive_en),
      .grant_id  (grant_id),
      .bus_busy  (bus_busy),
      .timeout   (timeout),
      .fsm_state (fsm_state)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [W-1:0] exp_q[$];
   int         grant_log[$];
   int         to_count = 0;
   bit         model_en = 1'b0;
   int         m_owner, m_held, m_last;
   int         wait_c[N];
   logic       prev_busy = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Ownership model: who owns the bus, how long, and who won last.
   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_last  = N - 1;
   endtask

   task automatic model_step(input logic [N-1:0] r);
      logic           to;
      logic [N-1:0]   e_drv;
      logic [IDW-1:0] e_gid;
      logic           e_busy;
      int             best, bestd, d;
      to = 1'b0;
      if (m_owner >= 0) begin
         if (!r[m_owner]) m_owner = -1;
         else if (m_held == MAXH) begin
            m_owner = -1;
            to      = 1'b1;
         end else m_held++;
      end else begin
         best  = -1;
         bestd = N;
         for (int s = 0; s < N; s++) begin
            if (r[s]) begin
               d = (s - m_last - 1 + 2 * N) % N;
               if (d < bestd) begin
                  bestd = d;
                  best  = s;
               end
            end
         end
         if (best >= 0) begin
            m_owner = best;
            m_last  = best;
            m_held  = 1;
         end
      end
      e_busy = (m_owner >= 0);
      e_drv  = e_busy ? N'(1 << m_owner) : '0;
      e_gid  = e_busy ? IDW'(m_owner) : '0;
      exp_q.push_back({e_drv, e_gid, e_busy, to});
   endtask

   always @(posedge clk) begin
      if (model_en && rst_n) model_step(req);
   end

   // Monitor: pops one expectation per active cycle, plus contention and starvation checks.
   always @(posedge clk) begin
      logic [W-1:0] e;
      int           worst;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("drive_en", 32'(drive_en), 32'(e[W-1 -: N]));
         check("bus_busy", 32'(bus_busy), 32'(e[1]));
         check("timeout",  32'(timeout),  32'(e[0]));
         if (e[1]) check("grant_id", 32'(grant_id), 32'(e[2 +: IDW]));
      end
      if (!rst_n) begin
         for (int s = 0; s < N; s++) wait_c[s] = 0;
         prev_busy = 1'b0;
      end else begin
         if (bus_busy && !prev_busy) grant_log.push_back(int'(grant_id));
         prev_busy = bus_busy;
         if (timeout) to_count++;
         check("onehot", 32'($countones(drive_en) <= 1), 32'd1);
         worst = 0;
         for (int s = 0; s < N; s++) begin
            if (drive_en[s] || !req[s]) wait_c[s] = 0;
            else wait_c[s]++;
            if (wait_c[s] > worst) worst = wait_c[s];
         end
         check("starve", 32'(worst <= STARVE_LIMIT), 32'd1);
      end
   end

   task automatic drive(input logic [N-1:0] v, input int n);
      req = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      model_en = 1'b0;
      req      = '0;
      rst_n    = 1'b0;
      #1;
      check("rst_drive_en", 32'(drive_en), 32'd0);
      check("rst_bus_busy", 32'(bus_busy), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_timeout",  32'(timeout),  32'd0);
      check("rst_state",    32'(fsm_state), 32'(IDLE));
      exp_q.delete();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n    = 1'b1;
      model_en = 1'b1;
      grant_log.delete();
      to_count = 0;
   endtask

   int rr_order[5] = '{0, 1, 2, 3, 0};

   initial begin
      logic [N-1:0] nr;
      model_reset();

      // Single requester: three cycles of ownership.
      do_reset();
      drive(4'b0001, 3);
      drive(4'b0000, 3);
      check("single_grants", 32'(grant_log.size()), 32'd1);

      // All requesting: strict rotation starting at source 0, with timeouts.
      do_reset();
      drive(4'b1111, 5 * (MAXH + 1) + 2);
      drive(4'b0000, 3);
      check("rr_count_ok", 32'(grant_log.size() >= 5), 32'd1);
      for (int i = 0; i < 5; i++)
         if (i < grant_log.size()) check("rr_order", 32'(grant_log[i]), 32'(rr_order[i]));

      // Handover: source 0 drops, source 1 takes over after one idle cycle.
      do_reset();
      drive(4'b0011, 2);
      drive(4'b0010, 4);
      drive(4'b0000, 3);
      check("handover_count", 32'(grant_log.size()), 32'd2);
      if (grant_log.size() == 2) begin
         check("handover_first",  32'(grant_log[0]), 32'd0);
         check("handover_second", 32'(grant_log[1]), 32'd1);
      end

      // Timeout: lone holder re-granted after forced release.
      do_reset();
      drive(4'b0100, 2 * (MAXH + 1) + 2);
      drive(4'b0000, 3);
      check("timeout_grants", 32'(grant_log.size()), 32'd3);
      check("timeout_pulses", 32'(to_count), 32'd2);

      // Asynchronous reset while source 1 owns the bus.
      do_reset();
      drive(4'b0010, 3);
      @(posedge clk);
      #3;
      check("pre_async_drive", 32'(drive_en), 32'b0010);
      model_en = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("async_drive_en", 32'(drive_en), 32'd0);
      check("async_bus_busy", 32'(bus_busy), 32'd0);
      exp_q.delete();
      model_reset();
      @(negedge clk);
      req = 4'b1010;
      @(negedge clk);
      rst_n    = 1'b1;
      model_en = 1'b1;
      grant_log.delete();
      drive(4'b1010, 4);
      check("async_first_cnt", 32'(grant_log.size() >= 1), 32'd1);
      if (grant_log.size() >= 1) check("async_first_id", 32'(grant_log[0]), 32'd1);
      drive(4'b0000, 3);

      // Randomized contention: requests held for random spans.
      do_reset();
      nr = '0;
      for (int c = 0; c < 10000; c++) begin
         for (int s = 0; s < N; s++) begin
            if (nr[s]) begin
               if ($urandom_range(7, 0) == 0) nr[s] = 1'b0;
            end else if ($urandom_range(3, 0) == 0) nr[s] = 1'b1;
         end
         drive(nr, 1);
      end
      drive(4'b0000, MAXH + 4);
      check("drain", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
